// File: rtl/branch_delay_sequencer.sv
// PC owner for the MIPS CPU: steps through the branch delay slot before applying a taken redirect,
// and stops at HALT_ADDR. Define BRANCH_STATS_EN to add the taken/slot-stall counters.
//
// state | meaning
// SEQ   | sequential fetch; a retiring redirect latches its target
// SLOT  | delay-slot instruction at pc; its retirement applies pending_target
// HALT  | redirect to HALT_ADDR applied; frozen until reset
module branch_delay_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   input  logic        redirect,
   input  logic [31:0] target,
   output logic [31:0] pc,
   output logic        in_delay_slot,
   output logic        halted,
`ifdef BRANCH_STATS_EN
   output logic [31:0] taken_count,
   output logic [31:0] slot_stall_cycles,
`endif
   output logic        err_slot_redirect
);

   typedef enum logic [1:0] {
      SEQ  = 2'd0,
      SLOT = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pending_target, pending_target_nxt;
   logic [31:0] pc_nxt;
   logic        in_delay_slot_nxt;
   logic        halted_nxt;
   logic        err_slot_redirect_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= SEQ;
         pc                <= RESET_VECTOR;
         pending_target    <= 32'h0;
         in_delay_slot     <= 1'b0;
         halted            <= 1'b0;
         err_slot_redirect <= 1'b0;
      end else begin
         state             <= state_nxt;
         pc                <= pc_nxt;
         pending_target    <= pending_target_nxt;
         in_delay_slot     <= in_delay_slot_nxt;
         halted            <= halted_nxt;
         err_slot_redirect <= err_slot_redirect_nxt;
      end
   end

   always_comb begin
      state_nxt             = state;
      pc_nxt                = pc;
      pending_target_nxt    = pending_target;
      in_delay_slot_nxt     = in_delay_slot;
      halted_nxt            = halted;
      err_slot_redirect_nxt = err_slot_redirect;
      case (state)
         SEQ: begin
            if (advance) begin
               pc_nxt = pc + 32'd4;
               if (redirect) begin
                  pending_target_nxt = {target[31:2], 2'b00};
                  in_delay_slot_nxt  = 1'b1;
                  state_nxt          = SLOT;
               end
            end
         end
         SLOT: begin
            if (advance) begin
               pc_nxt            = pending_target;
               in_delay_slot_nxt = 1'b0;
               // A branch in the delay slot is architecturally undefined; drop it and flag it.
               if (redirect) err_slot_redirect_nxt = 1'b1;
               if (pending_target == HALT_ADDR) begin
                  state_nxt  = HALT;
                  halted_nxt = 1'b1;
               end else begin
                  state_nxt = SEQ;
               end
            end
         end
         HALT: begin
            halted_nxt = 1'b1;
         end
         default: begin
            state_nxt = SEQ;
         end
      endcase
   end

`ifdef BRANCH_STATS_EN
   localparam logic [31:0] CNT_MAX = 32'hFFFFFFFF;

   always_ff @(posedge clk) begin
      if (reset) begin
         taken_count       <= 32'h0;
         slot_stall_cycles <= 32'h0;
      end else begin
         if (state == SEQ && advance && redirect && taken_count != CNT_MAX)
            taken_count <= taken_count + 32'd1;
         if (state == SLOT && !advance && slot_stall_cycles != CNT_MAX)
            slot_stall_cycles <= slot_stall_cycles + 32'd1;
      end
   end
`endif

endmodule
